// File: rtl/mips_muldiv_pkg.sv
// =============================================================================
// Module      : mips_muldiv_pkg
// Description : Shared multiply/divide op codes and FSM state encoding.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package mips_muldiv_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    // Operations that occupy the unit for more than the issue cycle.
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_div_core.sv
// =============================================================================
// Module      : mips_div_core
// Description : Iterative restoring unsigned divider, one quotient bit/cycle.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mips_div_core #(
    parameter int WIDTH      = 32,
    parameter int ITER_CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid
);

    logic [WIDTH-1:0]      r_quo;
    logic [WIDTH-1:0]      r_rem;
    logic [WIDTH-1:0]      r_dvsr;
    logic [ITER_CNT_W-1:0] r_cnt;
    logic                  r_active;
    logic                  r_valid;

    logic [WIDTH:0]        w_partial;
    logic                  w_ge;
    logic [WIDTH-1:0]      w_sub;

    // When the trial subtraction succeeds the true difference fits in WIDTH bits.
    assign w_partial = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_partial >= {1'b0, r_dvsr});
    assign w_sub     = w_partial[WIDTH-1:0] - r_dvsr;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvsr   <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_valid  <= 1'b0;
        end else if (start) begin
            r_quo    <= dividend;
            r_rem    <= '0;
            r_dvsr   <= divisor;
            r_cnt    <= '0;
            r_active <= 1'b1;
            r_valid  <= 1'b0;
        end else if (r_active) begin
            r_rem <= w_ge ? w_sub : w_partial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == ITER_CNT_W'(WIDTH - 1)) begin
                r_active <= 1'b0;
                r_valid  <= 1'b1;
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;
    assign valid     = r_valid;

endmodule

`default_nettype wire

// File: rtl/mips_muldiv.sv
// =============================================================================
// Module      : mips_muldiv
// Description : Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
//               Optional macro MIPS_MULDIV_FAST_MULT_EN: single-cycle multiply.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ITER_CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             md_start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] md_rs_data,
    input  logic [WIDTH-1:0] md_rt_data,
    input  logic             md_flush,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] md_hi,
    output logic [WIDTH-1:0] md_lo
);

    md_state_t             r_state;
    md_state_t             w_state_nxt;
    logic [WIDTH-1:0]      r_hi;
    logic [WIDTH-1:0]      r_lo;
    logic                  r_done;
    logic [ITER_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]      r_mcand;
    logic [2*WIDTH-1:0]    r_prod;
    logic                  r_is_div;
    logic                  r_neg_res;
    logic                  r_neg_rem;
    logic                  r_div_zero;
    logic [WIDTH-1:0]      r_rs_raw;

    logic                  w_signed;
    logic                  w_rs_neg;
    logic                  w_rt_neg;
    logic [WIDTH-1:0]      w_rs_abs;
    logic [WIDTH-1:0]      w_rt_abs;
    logic                  w_accept;
    logic                  w_launch;
    logic                  w_is_div_op;
    logic                  w_div_start;
    logic [WIDTH:0]        w_sum;
    logic [2*WIDTH-1:0]    w_mul_raw;
    logic [2*WIDTH-1:0]    w_mul_res;
    logic [WIDTH-1:0]      w_div_q;
    logic [WIDTH-1:0]      w_div_r;
    logic                  w_div_valid;
    logic [WIDTH-1:0]      w_quo;
    logic [WIDTH-1:0]      w_rem;
    logic                  w_commit;

    assign w_signed    = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign w_rs_neg    = w_signed & md_rs_data[WIDTH-1];
    assign w_rt_neg    = w_signed & md_rt_data[WIDTH-1];
    assign w_rs_abs    = w_rs_neg ? (-md_rs_data) : md_rs_data;
    assign w_rt_abs    = w_rt_neg ? (-md_rt_data) : md_rt_data;
    assign w_accept    = (r_state == ST_IDLE) && md_start && !md_flush;
    assign w_launch    = w_accept && md_is_arith(md_op);
    assign w_is_div_op = (md_op == MD_DIV) || (md_op == MD_DIVU);
    assign w_div_start = w_launch && w_is_div_op;

    mips_div_core #(
        .WIDTH      (WIDTH),
        .ITER_CNT_W (ITER_CNT_W)
    ) u_div_core (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (w_div_start),
        .dividend  (w_rs_abs),
        .divisor   (w_rt_abs),
        .quotient  (w_div_q),
        .remainder (w_div_r),
        .valid     (w_div_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
`ifdef MIPS_MULDIV_FAST_MULT_EN
                    w_state_nxt = w_is_div_op ? ST_RUN : ST_FIX;
`else
                    w_state_nxt = ST_RUN;
`endif
                end
            end
            ST_RUN:  if (r_cnt == ITER_CNT_W'(WIDTH - 1)) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (md_flush) w_state_nxt = ST_IDLE;
    end

    // Shift-add step: upper half accumulates, whole product shifts right.
    assign w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_prod[0] ? r_mcand : {WIDTH{1'b0}})};

`ifdef MIPS_MULDIV_FAST_MULT_EN
    assign w_mul_raw = {{WIDTH{1'b0}}, r_mcand} * {{WIDTH{1'b0}}, r_prod[WIDTH-1:0]};
`else
    assign w_mul_raw = r_prod;
`endif

    assign w_mul_res = r_neg_res ? (-w_mul_raw) : w_mul_raw;
    assign w_quo     = r_neg_res ? (-w_div_q) : w_div_q;
    assign w_rem     = r_neg_rem ? (-w_div_r) : w_div_r;
    assign w_commit  = (r_state == ST_FIX) && !md_flush && (!r_is_div || w_div_valid);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= ST_IDLE;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_cnt      <= '0;
            r_mcand    <= '0;
            r_prod     <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_rs_raw   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_commit;
            if (w_launch) begin
                r_mcand    <= w_rs_abs;
                r_prod     <= {{WIDTH{1'b0}}, w_rt_abs};
                r_is_div   <= w_is_div_op;
                r_neg_res  <= w_rs_neg ^ w_rt_neg;
                r_neg_rem  <= w_rs_neg;
                r_div_zero <= (md_rt_data == '0);
                r_rs_raw   <= md_rs_data;
                r_cnt      <= '0;
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt + 1'b1;
                if (!r_is_div) r_prod <= {w_sum, r_prod[WIDTH-1:1]};
            end
            if (w_accept && (md_op == MD_MTHI)) r_hi <= md_rs_data;
            if (w_accept && (md_op == MD_MTLO)) r_lo <= md_rs_data;
            if (w_commit) begin
                if (!r_is_div) begin
                    r_hi <= w_mul_res[2*WIDTH-1:WIDTH];
                    r_lo <= w_mul_res[WIDTH-1:0];
                end else if (r_div_zero) begin
                    // Divide by zero returns all-ones quotient and the raw dividend.
                    r_hi <= r_rs_raw;
                    r_lo <= {WIDTH{1'b1}};
                end else begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end
            end
        end
    end

    assign md_busy = (r_state != ST_IDLE);
    assign md_done = r_done;
    assign md_hi   = r_hi;
    assign md_lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mips_muldiv.sv
// =============================================================================
// Module      : tb_mips_muldiv
// Description : Directed self-checking bench for mips_muldiv.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mips_muldiv;
    import mips_muldiv_pkg::*;

`ifdef MIPS_MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic        clk;
    logic        rst_b;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_rs_data;
    logic [31:0] md_rt_data;
    logic        md_flush;
    logic        md_busy;
    logic        md_done;
    logic [31:0] md_hi;
    logic [31:0] md_lo;

    int n_tests;
    int n_fail;

    mips_muldiv #(.WIDTH(32), .ITER_CNT_W(6)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .md_start   (md_start),
        .md_op      (md_op),
        .md_rs_data (md_rs_data),
        .md_rt_data (md_rt_data),
        .md_flush   (md_flush),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .md_hi      (md_hi),
        .md_lo      (md_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp_v);
        end
    endtask

    // Issue at a negedge (cycle N), then measure cycles until busy drops.
    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] eh, input logic [31:0] el, input int lat, input string nm);
        int k;
        @(negedge clk);
        md_start = 1'b1; md_op = op; md_rs_data = rs; md_rt_data = rt;
        @(negedge clk);
        md_start = 1'b0; md_op = MD_NONE;
        k = 1;
        while (md_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (k != lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", nm, k, lat);
        end
        chk({nm, " done"}, {31'd0, md_done}, 32'd1);
        chk({nm, " hi"}, md_hi, eh);
        chk({nm, " lo"}, md_lo, el);
        @(negedge clk);
        chk({nm, " done clears"}, {31'd0, md_done}, 32'd0);
    endtask

    task automatic test_reset();
        rst_b = 1'b0; md_start = 1'b0; md_op = MD_NONE;
        md_rs_data = '0; md_rt_data = '0; md_flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, md_busy}, 32'd0);
        chk("reset done", {31'd0, md_done}, 32'd0);
        chk("reset hi", md_hi, 32'd0);
        chk("reset lo", md_lo, 32'd0);
        rst_b = 1'b1;
    endtask

    task automatic test_mult();
        run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT, "mult");
        run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MUL_LAT, "multu");
        run_op(MD_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT, "mult_m3x5");
        run_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, MUL_LAT, "multu_carry");
    endtask

    task automatic test_div();
        run_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT, "divu");
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, "div_neg");
        run_op(MD_DIV, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, DIV_LAT, "div_zero");
        run_op(MD_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, DIV_LAT, "div_zero_neg");
        run_op(MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DIV_LAT, "divu_zero");
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT, "div_ovf");
    endtask

    task automatic test_mtxx();
        @(negedge clk);
        md_start = 1'b1; md_op = MD_MTHI; md_rs_data = 32'h0000_AAAA;
        @(negedge clk);
        md_op = MD_MTLO; md_rs_data = 32'h0000_5555;
        chk("mthi visible", md_hi, 32'h0000_AAAA);
        chk("mthi busy", {31'd0, md_busy}, 32'd0);
        @(negedge clk);
        md_start = 1'b0; md_op = MD_NONE;
        chk("mtlo visible", md_lo, 32'h0000_5555);
        chk("mtlo done", {31'd0, md_done}, 32'd0);
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        md_start = 1'b1; md_op = MD_MULTU; md_rs_data = 32'd3; md_rt_data = 32'd4;
        @(negedge clk);
        md_start = 1'b0; md_op = MD_NONE;
        repeat (2) @(negedge clk);
        md_start = 1'b1; md_op = MD_MTHI; md_rs_data = 32'h0000_1111;
        @(negedge clk);
        md_start = 1'b0; md_op = MD_NONE;
        chk("mthi while busy", md_hi, 32'h0000_AAAA);
        repeat (6) @(negedge clk);
        md_flush = 1'b1;
        @(negedge clk);
        md_flush = 1'b0;
        chk("flush busy", {31'd0, md_busy}, 32'd0);
        chk("flush hi", md_hi, 32'h0000_AAAA);
        chk("flush lo", md_lo, 32'h0000_5555);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (md_done) seen++;
        end
        chk("flush no done", seen, 0);

        // Flush in the FIX cycle beats the commit.
        @(negedge clk);
        md_start = 1'b1; md_op = MD_DIVU; md_rs_data = 32'd100; md_rt_data = 32'd7;
        @(negedge clk);
        md_start = 1'b0; md_op = MD_NONE;
        repeat (32) @(negedge clk);
        chk("fix busy", {31'd0, md_busy}, 32'd1);
        md_flush = 1'b1;
        @(negedge clk);
        md_flush = 1'b0;
        chk("fix flush done", {31'd0, md_done}, 32'd0);
        chk("fix flush busy", {31'd0, md_busy}, 32'd0);
        chk("fix flush lo", md_lo, 32'h0000_5555);

        @(negedge clk);
        md_start = 1'b1; md_flush = 1'b1; md_op = MD_DIVU; md_rs_data = 32'd9; md_rt_data = 32'd3;
        @(negedge clk);
        md_start = 1'b0; md_flush = 1'b0; md_op = MD_NONE;
        chk("flush+start busy", {31'd0, md_busy}, 32'd0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        md_start = 1'b1; md_op = MD_DIV; md_rs_data = 32'd1000; md_rt_data = 32'd3;
        @(negedge clk);
        md_start = 1'b0; md_op = MD_NONE;
        repeat (19) @(negedge clk);
        chk("pre-reset busy", {31'd0, md_busy}, 32'd1);
        #2 rst_b = 1'b0;
        #1;
        chk("async busy", {31'd0, md_busy}, 32'd0);
        chk("async hi", md_hi, 32'd0);
        chk("async lo", md_lo, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        run_op(MD_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, DIV_LAT, "divu_after_rst");
    endtask

    task automatic test_back_to_back();
        run_op(MD_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, MUL_LAT, "b2b_mul");
        run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_LAT, "b2b_div");
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_mult();
        test_div();
        test_mtxx();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
